// File: rtl/cipher_byte_framer.sv
// Frame buffer in front of a bit-serial stream cipher: fill N bytes, stream 8*N bits through the cipher with no stalls, drain.
// The cipher is held at its seed (ciph_reset=1) outside STREAM, so every frame starts from the same keystream position.
module cipher_byte_framer #(
  parameter int FRAME_BYTES = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ciph_reset,
  output logic       ciph_pt,
  input  logic       ciph_ct,
  output logic       busy,
  output logic       frame_done
);

  localparam int IW    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] LAST = IW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          in_ready_q, in_ready_d;
  logic          ciph_reset_q, ciph_reset_d;

  logic [7:0]    buf_q [DEPTH];
  logic          buf_we;
  logic [7:0]    buf_wdat;

  logic [7:0]    cur_byte;
  logic [2:0]    bsel;
  logic [7:0]    sr_new;

  assign cur_byte = buf_q[idx_q];
  assign bsel     = MSB_FIRST ? (3'd7 - bcnt_q) : bcnt_q;
  // Returned bits are gathered in the same order they were sent out.
  assign sr_new   = MSB_FIRST ? {sr_q[6:0], ciph_ct} : {ciph_ct, sr_q[7:1]};

  assign ciph_pt    = (state_q == STREAM) & cur_byte[bsel];
  assign in_ready   = in_ready_q;
  assign ciph_reset = ciph_reset_q;
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = out_valid ? cur_byte : 8'h00;
  assign busy       = (state_q != FILL);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    sr_d         = sr_q;
    in_ready_d   = in_ready_q;
    ciph_reset_d = ciph_reset_q;
    buf_we       = 1'b0;
    buf_wdat     = sr_new;
    frame_done   = 1'b0;

    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          buf_we   = 1'b1;
          buf_wdat = in_data;
          if (idx_q == LAST) begin
            idx_d        = '0;
            bcnt_d       = 3'd0;
            state_d      = STREAM;
            in_ready_d   = 1'b0;
            ciph_reset_d = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      STREAM: begin
        sr_d   = sr_new;
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          // Ciphertext overwrites the plaintext byte it came from.
          buf_we   = 1'b1;
          buf_wdat = sr_new;
          if (idx_q == LAST) begin
            idx_d        = '0;
            state_d      = DRAIN;
            ciph_reset_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            frame_done = 1'b1;
            state_d    = FILL;
            in_ready_d = 1'b1;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      default: begin
        state_d      = FILL;
        idx_d        = '0;
        bcnt_d       = 3'd0;
        in_ready_d   = 1'b1;
        ciph_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      idx_q        <= '0;
      bcnt_q       <= 3'd0;
      sr_q         <= 8'h00;
      in_ready_q   <= 1'b1;
      ciph_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      sr_q         <= sr_d;
      in_ready_q   <= in_ready_d;
      ciph_reset_q <= ciph_reset_d;
    end
  end

  // Frame storage needs no reset: every entry is rewritten by FILL before it is read.
  always_ff @(posedge clk) begin
    if (buf_we && !reset) begin
      buf_q[idx_q] <= buf_wdat;
    end
  end

endmodule
